// File: rtl/instr_encoder.sv
// instr_encoder: assembles RISC-V machine words from decoded fields and writes
// them into instruction memory at sequential word addresses.
module instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_illegal,
    output logic              err_range,
    output logic [ADDR_W:0]   count,
    output logic              full
);
    logic signed [31:0] imm;
    logic               fit_i, fit_b, fit_j, in_range, illegal, accept, write;
    logic [31:0]        word;

    assign imm      = $signed(in_imm);
    assign fit_i    = imm >= -32'sd2048 && imm <= 32'sd2047;
    assign fit_b    = imm >= -32'sd4096 && imm <= 32'sd4094 && !imm[0];
    assign fit_j    = imm >= -32'sd1048576 && imm <= 32'sd1048574 && !imm[0];
    assign illegal  = in_class[2] && in_class[1];
    assign full     = count[ADDR_W];
    assign in_ready = !full && !start;
    assign accept   = in_valid && in_ready;
    assign write    = accept && !illegal && in_range;

    always_comb begin
        word     = '0;
        in_range = 1'b1;
        case (in_class)
            3'd0: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: begin
                word     = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                in_range = fit_i;
            end
            3'd2: begin
                word     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], 7'b1100011};
                in_range = fit_b;
            end
            3'd3: begin
                word     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                in_range = fit_j;
            end
            3'd4: begin
                word     = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                in_range = fit_i;
            end
            3'd5: begin
                word     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                in_range = fit_i;
            end
            default: word = '0;
        endcase
    end

    // Dropped (errored) transfers are consumed but leave address and count untouched.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            imem_we     <= 1'b0;
            imem_addr   <= BASE_ADDR;
            imem_wdata  <= '0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
            count       <= '0;
        end else begin
            imem_we     <= write;
            err_illegal <= accept && illegal;
            err_range   <= accept && !illegal && !in_range;
            if (write) begin
                imem_addr  <= BASE_ADDR + count[ADDR_W-1:0];
                imem_wdata <= word;
            end
            if (start)
                count <= '0;
            else if (write)
                count <= count + (ADDR_W+1)'(1);
        end
    end
endmodule
